// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB4 master arbiter.
// Imported by the interface, the round-robin arbiter and the top.
package apb_pkg;

    localparam int unsigned NUM_REQ_D = 2;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned STRB_W    = DATA_W / 8;
    localparam int unsigned PROT_W    = 3;
    localparam int unsigned TIMEOUT_D = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
        logic [PROT_W-1:0] prot;
    } apb_req_t;

    function automatic int unsigned idx_w(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_master_arbiter_if.sv
// APB4 bus bundle between the master sequencer and a slave.
// Signal names follow the APB4 pin names.
interface apb_master_arbiter_if
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W,
    parameter int STRB_WIDTH = STRB_W,
    parameter int PROT_WIDTH = PROT_W
);

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [STRB_WIDTH-1:0] PSTRB;
    logic [PROT_WIDTH-1:0] PPROT;
    logic                  PREADY;
    logic                  PSLVERR;
    logic [DATA_WIDTH-1:0] PRDATA;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        input  PREADY, PSLVERR, PRDATA
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        output PREADY, PSLVERR, PRDATA
    );

endinterface

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr.
// Produces one-hot grant, its index and an any-request flag.
module apb_rr_arbiter
    import apb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int j;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB4 master shared by NUM_REQ requesters: round-robin grant,
// one SETUP->ACCESS transfer per grant, response routed to the owner.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_D,
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W,
    parameter int STRB_WIDTH = STRB_W,
    parameter int PROT_WIDTH = PROT_W,
    parameter int TIMEOUT    = TIMEOUT_D
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    input  logic [NUM_REQ*STRB_WIDTH-1:0]  req_strb,
    input  logic [NUM_REQ*PROT_WIDTH-1:0]  req_prot,
    output logic [NUM_REQ-1:0]             req_grant,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           rsp_slverr,
    apb_master_arbiter_if.master           apb
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CMAX = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IW-1:0] ILAST = IW'(NUM_REQ - 1);

    apb_state_e state, state_nxt;

    logic [IW-1:0]      ptr;
    logic [IW-1:0]      owner;
    logic [CW-1:0]      cnt;
    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]      gidx;
    logic               any;
    logic               arb_en;
    logic               take;
    logic               done;
    logic               tmo;
    logic [IW-1:0]      ptr_nxt;
    logic [NUM_REQ-1:0] own_oh;

    logic                  sel_w;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [STRB_WIDTH-1:0] sel_strb;
    logic [PROT_WIDTH-1:0] sel_prot;

    apb_rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gidx),
        .any (any)
    );

    assign sel_w     = req_write[gidx];
    assign sel_addr  = req_addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata = req_wdata[gidx*DATA_WIDTH +: DATA_WIDTH];
    assign sel_strb  = req_strb[gidx*STRB_WIDTH +: STRB_WIDTH];
    assign sel_prot  = req_prot[gidx*PROT_WIDTH +: PROT_WIDTH];

    assign ptr_nxt = (gidx == ILAST) ? '0 : gidx + 1'b1;

    always_comb begin
        own_oh        = '0;
        own_oh[owner] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        arb_en    = 1'b0;
        done      = 1'b0;
        tmo       = 1'b0;
        unique case (state)
            IDLE: begin
                arb_en = 1'b1;
            end
            SETUP: begin
                state_nxt = ACCESS;
            end
            ACCESS: begin
                if (apb.PREADY) begin
                    done      = 1'b1;
                    arb_en    = 1'b1;
                    state_nxt = IDLE;
                end else if (TIMEOUT != 0 && cnt == CMAX) begin
                    done      = 1'b1;
                    tmo       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        take = arb_en & any;
        if (take) state_nxt = SETUP;
    end

    // Grant is gated by reset so every output reads 0 while PRESETn is low.
    assign req_grant = (take && PRESETn) ? gnt : '0;

    assign apb.PSEL    = (state != IDLE);
    assign apb.PENABLE = (state == ACCESS);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            cnt        <= '0;
            apb.PWRITE <= 1'b0;
            apb.PADDR  <= '0;
            apb.PWDATA <= '0;
            apb.PSTRB  <= '0;
            apb.PPROT  <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= (state == ACCESS && !done) ? cnt + 1'b1 : '0;
            if (take) begin
                ptr        <= ptr_nxt;
                owner      <= gidx;
                apb.PWRITE <= sel_w;
                apb.PADDR  <= sel_addr;
                apb.PWDATA <= sel_w ? sel_wdata : '0;
                apb.PSTRB  <= sel_w ? sel_strb : '0;
                apb.PPROT  <= sel_prot;
            end
            rsp_valid  <= done ? own_oh : '0;
            rsp_rdata  <= (done && !tmo && !apb.PWRITE) ? apb.PRDATA : '0;
            rsp_slverr <= done && (tmo || apb.PSLVERR);
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with a transaction-level model
// checked every cycle plus hand-computed expectations.
module tb_apb_master_arbiter;
    import apb_pkg::*;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int PW = 3;
    localparam int TO = 16;

    logic            PCLK = 1'b0;
    logic            PRESETn = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N*SW-1:0] req_strb;
    logic [N*PW-1:0] req_prot;
    logic [N-1:0]    req_grant;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_slverr;

    apb_master_arbiter_if #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .STRB_WIDTH (SW),
        .PROT_WIDTH (PW)
    ) apb ();

    apb_master_arbiter #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .STRB_WIDTH (SW),
        .PROT_WIDTH (PW),
        .TIMEOUT    (TO)
    ) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_strb   (req_strb),
        .req_prot   (req_prot),
        .req_grant  (req_grant),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_slverr (rsp_slverr),
        .apb        (apb)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge PCLK) cyc <= cyc + 1;

    // Slave: small RAM, configurable wait states, hang and error injection.
    int          stall = 0;
    bit          hang = 1'b0;
    bit          perr = 1'b0;
    int          acc_cnt = 0;
    logic [DW-1:0] mem [0:15];

    assign apb.PREADY  = apb.PSEL && apb.PENABLE && !hang && (acc_cnt >= stall);
    assign apb.PSLVERR = perr && apb.PREADY;
    assign apb.PRDATA  = (apb.PSEL && apb.PENABLE && !apb.PWRITE)
                         ? mem[apb.PADDR[5:2]] : '0;

    always @(posedge PCLK) begin
        if (apb.PSEL && apb.PENABLE && !apb.PREADY) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
        if (apb.PSEL && apb.PENABLE && apb.PREADY && apb.PWRITE)
            for (int b = 0; b < SW; b++)
                if (apb.PSTRB[b])
                    mem[apb.PADDR[5:2]][8*b +: 8] <= apb.PWDATA[8*b +: 8];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: no DUT event within bound (cycle %0d)", nm, cyc);
    endtask

    // Transaction-level model: one transfer in flight, phase counted from grant.
    bit            m_act;
    int            m_ph;
    int            m_owner;
    int            m_ptr;
    logic          m_w;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_strb;
    logic [PW-1:0] m_prot;
    logic [N-1:0]  m_rsp;
    logic [DW-1:0] m_rdata;
    logic          m_err;

    task automatic model_reset();
        m_act = 0; m_ph = 0; m_owner = 0; m_ptr = 0;
        m_w = 0; m_addr = 0; m_wdata = 0; m_strb = 0; m_prot = 0;
        m_rsp = 0; m_rdata = 0; m_err = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge PCLK);
            if (!PRESETn) begin
                chk("rst_bus", {apb.PSEL, apb.PENABLE, apb.PWRITE}, 0);
                chk("rst_grant", req_grant, 0);
                chk("rst_rsp", {rsp_valid, rsp_slverr}, 0);
                chk("rst_rdata", rsp_rdata, 0);
                chk("rst_fields", {apb.PADDR, apb.PSTRB, apb.PPROT}, 0);
                model_reset();
            end else begin
                bit           done, arb;
                int           g;
                logic [N-1:0] eg;
                chk("psel", apb.PSEL, m_act);
                chk("penable", apb.PENABLE, m_act && m_ph >= 2);
                chk("paddr", apb.PADDR, m_addr);
                chk("pwrite", apb.PWRITE, m_w);
                chk("pwdata", apb.PWDATA, m_wdata);
                chk("pstrb", apb.PSTRB, m_strb);
                chk("pprot", apb.PPROT, m_prot);
                chk("rsp_valid", rsp_valid, m_rsp);
                if (m_rsp != 0) begin
                    chk("rsp_rdata", rsp_rdata, m_rdata);
                    chk("rsp_slverr", rsp_slverr, m_err);
                end
                done = m_act && m_ph >= 2 && (apb.PREADY || (TO != 0 && m_ph == TO + 1));
                arb  = !m_act || (m_ph >= 2 && apb.PREADY);
                g = -1;
                if (arb)
                    for (int k = 0; k < N; k++)
                        if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                eg = 0;
                if (g >= 0) eg[g] = 1'b1;
                chk("grant", req_grant, eg);
                m_rsp = 0;
                if (done) m_rsp[m_owner] = 1'b1;
                m_rdata = (done && apb.PREADY && !m_w) ? apb.PRDATA : '0;
                m_err   = done && (!apb.PREADY || apb.PSLVERR);
                if (g >= 0) begin
                    m_act = 1; m_ph = 1; m_owner = g; m_ptr = (g + 1) % N;
                    m_w     = req_write[g];
                    m_addr  = req_addr[g*AW +: AW];
                    m_wdata = m_w ? req_wdata[g*DW +: DW] : '0;
                    m_strb  = m_w ? req_strb[g*SW +: SW] : '0;
                    m_prot  = req_prot[g*PW +: PW];
                end else if (done) begin
                    m_act = 0;
                end else if (m_act) begin
                    m_ph++;
                end
            end
        end
    end

    task automatic set_req(input int i, input bit w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s,
                           input logic [PW-1:0] p);
        req_write[i]         = w;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
        req_strb[i*SW +: SW] = s;
        req_prot[i*PW +: PW] = p;
    endtask

    task automatic issue(input int i, input bit w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s,
                         input logic [PW-1:0] p, output int tg);
        int k;
        set_req(i, w, a, d, s, p);
        req_valid[i] = 1'b1;
        tg = -1;
        k = 0;
        while (tg < 0 && k < 40) begin
            @(negedge PCLK);
            if (req_grant[i]) tg = cyc;
            k++;
        end
        if (tg < 0) bound_fail("grant_wait");
        @(posedge PCLK);
        #1 req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(input int i, output int t, output logic [DW-1:0] rd,
                            output logic er);
        int k;
        t = -1; rd = '0; er = 1'b0;
        k = 0;
        while (t < 0 && k < 60) begin
            @(negedge PCLK);
            if (rsp_valid[i]) begin
                t = cyc; rd = rsp_rdata; er = rsp_slverr;
            end
            k++;
        end
        if (t < 0) bound_fail("rsp_wait");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            tg, tr, nacc, n, k;
        logic [DW-1:0] rd;
        logic          er;
        logic [N-1:0]  rv;
        int            gs [4];
        int            gc [4];

        req_valid = '0; req_write = '0; req_addr = '0;
        req_wdata = '0; req_strb = '0; req_prot = '0;
        repeat (3) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        @(posedge PCLK);
        #1;

        // 1: single write, fixed latency, read back
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'h0, tg);
        @(negedge PCLK);
        chk("t1_setup", {apb.PSEL, apb.PENABLE}, 2'b10);
        @(negedge PCLK);
        chk("t1_access", {apb.PSEL, apb.PENABLE}, 2'b11);
        @(negedge PCLK);
        chk("t1_rsp", rsp_valid, 2'b01);
        chk("t1_err", rsp_slverr, 1'b0);
        @(posedge PCLK);
        #1;
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'h0, tg);
        wait_rsp(0, tr, rd, er);
        chk("t1_rdata", rd, 32'hDEADBEEF);
        chk("t1_latency", tr - tg, 3);
        @(posedge PCLK);
        #1;
        issue(1, 1'b1, 32'h14, 32'h12345678, 4'h3, 3'h2, tg);
        wait_rsp(1, tr, rd, er);
        chk("t1b_err", er, 1'b0);
        @(posedge PCLK);
        #1;

        // 2: both requesters continuously valid -> alternation, no idle gap
        set_req(0, 1'b1, 32'h20, 32'hA0A0A0A0, 4'hF, 3'h1);
        set_req(1, 1'b1, 32'h24, 32'hB1B1B1B1, 4'hC, 3'h3);
        req_valid = 2'b11;
        n = 0; k = 0;
        while (n < 4 && k < 40) begin
            @(negedge PCLK);
            if (req_grant != 0) begin
                gs[n] = int'(req_grant[1]);
                gc[n] = cyc;
                n++;
            end
            k++;
        end
        @(posedge PCLK);
        #1 req_valid = '0;
        if (n < 4) bound_fail("t2_grants");
        else begin
            for (int j = 0; j < 4; j++) chk("t2_order", gs[j], j % 2);
            for (int j = 1; j < 4; j++) chk("t2_gap", gc[j] - gc[j-1], 2);
        end
        repeat (6) @(posedge PCLK);
        #1;

        // 3: read with 3 wait states
        stall = 3;
        issue(0, 1'b0, 32'h10, 32'hFFFFFFFF, 4'hF, 3'h5, tg);
        wait_rsp(0, tr, rd, er);
        chk("t3_latency", tr - tg, 6);
        chk("t3_rdata", rd, 32'hDEADBEEF);
        chk("t3_err", er, 1'b0);
        stall = 0;
        @(posedge PCLK);
        #1;

        // 4: slave never ready -> timeout after 16 ACCESS cycles
        hang = 1'b1;
        issue(1, 1'b0, 32'h10, 32'h0, 4'h0, 3'h0, tg);
        nacc = 0; tr = -1; k = 0;
        while (tr < 0 && k < 60) begin
            @(negedge PCLK);
            if (apb.PSEL && apb.PENABLE) nacc++;
            if (rsp_valid[1]) begin
                tr = cyc;
                chk("t4_err", rsp_slverr, 1'b1);
                chk("t4_rdata", rsp_rdata, 32'h0);
                chk("t4_psel", apb.PSEL, 1'b0);
            end
            k++;
        end
        if (tr < 0) bound_fail("t4_rsp");
        chk("t4_access_cycles", nacc, 16);
        chk("t4_latency", tr - tg, 18);
        hang = 1'b0;
        @(posedge PCLK);
        #1;

        // 5: PSLVERR reported to the owner only
        perr = 1'b1;
        issue(0, 1'b1, 32'h18, 32'h55, 4'hF, 3'h0, tg);
        rv = '0; k = 0;
        while (rv == 0 && k < 20) begin
            @(negedge PCLK);
            rv = rsp_valid;
            er = rsp_slverr;
            k++;
        end
        chk("t5_rsp_vec", rv, 2'b01);
        chk("t5_err", er, 1'b1);
        perr = 1'b0;
        @(posedge PCLK);
        #1;
        issue(1, 1'b0, 32'h14, 32'h0, 4'h0, 3'h0, tg);
        wait_rsp(1, tr, rd, er);
        chk("t5_rdata_lo", rd[15:0], 16'h5678);
        chk("t5_err_clear", er, 1'b0);
        @(posedge PCLK);
        #1;

        // 6: reset during ACCESS aborts; pointer returns to 0
        stall = 5;
        issue(0, 1'b1, 32'h1C, 32'h77, 4'hF, 3'h0, tg);
        @(negedge PCLK);
        @(negedge PCLK);
        #2 PRESETn = 1'b0;
        set_req(1, 1'b0, 32'h28, 32'h0, 4'h0, 3'h0);
        set_req(0, 1'b0, 32'h2C, 32'h0, 4'h0, 3'h0);
        req_valid = 2'b11;
        #1;
        chk("t6_async", {apb.PSEL, apb.PENABLE, req_grant, rsp_valid}, 0);
        stall = 0;
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        rv = '0; k = 0;
        while (rv == 0 && k < 10) begin
            @(negedge PCLK);
            rv = req_grant;
            k++;
        end
        chk("t6_first_grant", rv, 2'b01);
        @(posedge PCLK);
        #1 req_valid = '0;
        repeat (10) @(posedge PCLK);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
